// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Grants and memory drive are combinational; responses return one cycle later via a registered tag.
module dmem_arbiter #(
   parameter int unsigned MEM_ADDR_WIDTH = 14
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_m0_req,
   input  logic        i_m0_write,
   input  logic [31:0] i_m0_addr,
   input  logic [31:0] i_m0_wr_data,
   input  logic [3:0]  i_m0_size,
   input  logic        i_m1_req,
   input  logic        i_m1_write,
   input  logic [31:0] i_m1_addr,
   input  logic [31:0] i_m1_wr_data,
   input  logic [3:0]  i_m1_size,
   output logic        o_m0_gnt,
   output logic        o_m0_rvalid,
   output logic [31:0] o_m0_rd_data,
   output logic        o_m0_err,
   output logic        o_m1_gnt,
   output logic        o_m1_rvalid,
   output logic [31:0] o_m1_rd_data,
   output logic        o_m1_err,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wr_data,
   output logic [3:0]  o_mem_size,
   output logic        o_mem_write,
   output logic        o_mem_read,
   input  logic [31:0] i_mem_rd_data
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam logic [DATA_W-1:0] RANGE_MASK = DATA_W'((64'd1 << MEM_ADDR_WIDTH) - 64'd1);
   localparam logic [DATA_W-1:0] WORD_MASK  = RANGE_MASK & ~DATA_W'(3);

   // last_m1_q = 1 means m1 was granted most recently, so m0 wins the next tie
   logic last_m1_q;
   logic rsp_valid_q;
   logic rsp_read_q;
   logic rsp_err_q;
   logic rsp_m1_q;

   logic              gnt0;
   logic              gnt1;
   logic              any_gnt;
   logic              sel_write;
   logic [DATA_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wr_data;
   logic [STRB_W-1:0] sel_size;
   logic              sel_in_range;

   // Arbitration and request selection; reset forces everything idle
   always_comb begin
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      sel_write    = 1'b0;
      sel_addr     = '0;
      sel_wr_data  = '0;
      sel_size     = '0;
      if (i_rst_n) begin
         gnt0 = i_m0_req && (!i_m1_req || last_m1_q);
         gnt1 = i_m1_req && !gnt0;
      end
      if (gnt0) begin
         sel_write   = i_m0_write;
         sel_addr    = i_m0_addr;
         sel_wr_data = i_m0_wr_data;
         sel_size    = i_m0_size;
      end else if (gnt1) begin
         sel_write   = i_m1_write;
         sel_addr    = i_m1_addr;
         sel_wr_data = i_m1_wr_data;
         sel_size    = i_m1_size;
      end
      any_gnt      = gnt0 || gnt1;
      sel_in_range = (sel_addr & ~RANGE_MASK) == '0;
   end

   assign o_m0_gnt      = gnt0;
   assign o_m1_gnt      = gnt1;
   assign o_mem_addr    = sel_addr & WORD_MASK;
   assign o_mem_wr_data = sel_wr_data;
   assign o_mem_size    = sel_size;
   assign o_mem_write   = any_gnt && sel_write && sel_in_range;
   assign o_mem_read    = any_gnt && !sel_write && sel_in_range;

   // Round-robin pointer and response tag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_m1_q   <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_read_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_m1_q    <= 1'b0;
      end else begin
         if (any_gnt) begin
            last_m1_q <= gnt1;
         end
         rsp_valid_q <= any_gnt && (!sel_write || !sel_in_range);
         rsp_read_q  <= !sel_write;
         rsp_err_q   <= !sel_in_range;
         rsp_m1_q    <= gnt1;
      end
   end

   // Responses routed to the tagged owner; read data zeroed unless a clean read is returning
   always_comb begin
      o_m0_rvalid  = rsp_valid_q && rsp_read_q && !rsp_m1_q;
      o_m1_rvalid  = rsp_valid_q && rsp_read_q && rsp_m1_q;
      o_m0_err     = rsp_valid_q && rsp_err_q && !rsp_m1_q;
      o_m1_err     = rsp_valid_q && rsp_err_q && rsp_m1_q;
      o_m0_rd_data = (o_m0_rvalid && !rsp_err_q) ? i_mem_rd_data : '0;
      o_m1_rd_data = (o_m1_rvalid && !rsp_err_q) ? i_mem_rd_data : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change on the falling edge, outputs are checked
// just after it; a small word memory model answers reads one cycle after o_mem_read.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_write, m1_req, m1_write;
   logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data;
   logic [3:0]  m0_size, m1_size;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
   logic [3:0]  mem_size;
   logic        mem_write, mem_read;

   int tests = 0;
   int fails = 0;
   logic [31:0] mem [0:4095];

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_ADDR_WIDTH(14)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_req(m0_req), .i_m0_write(m0_write), .i_m0_addr(m0_addr),
      .i_m0_wr_data(m0_wr_data), .i_m0_size(m0_size),
      .i_m1_req(m1_req), .i_m1_write(m1_write), .i_m1_addr(m1_addr),
      .i_m1_wr_data(m1_wr_data), .i_m1_size(m1_size),
      .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rd_data(m0_rd_data), .o_m0_err(m0_err),
      .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rd_data(m1_rd_data), .o_m1_err(m1_err),
      .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wr_data), .o_mem_size(mem_size),
      .o_mem_write(mem_write), .o_mem_read(mem_read), .i_mem_rd_data(mem_rd_data)
   );

   // Memory model: junk on the bus when no read was issued, so unmasked rd_data shows up
   always @(posedge clk) begin
      if (mem_read) mem_rd_data <= mem[mem_addr[13:2]];
      else          mem_rd_data <= 32'hBAD0_BAD0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      m0_req = 0; m0_write = 0; m0_addr = 0; m0_wr_data = 0; m0_size = 0;
      m1_req = 0; m1_write = 0; m1_addr = 0; m1_wr_data = 0; m1_size = 0;
   endtask

   task automatic req0(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      m0_req = 1; m0_write = wr; m0_addr = a; m0_wr_data = d; m0_size = s;
   endtask

   task automatic req1(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      m1_req = 1; m1_write = wr; m1_addr = a; m1_wr_data = d; m1_size = s;
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, {30'd0, m0_gnt, m1_gnt}, 32'd0);
      chk({tag, "_rsp"}, {28'd0, m0_rvalid, m0_err, m1_rvalid, m1_err}, 32'd0);
      chk({tag, "_rd"}, m0_rd_data | m1_rd_data, 32'd0);
      chk({tag, "_mem"}, {26'd0, mem_write, mem_read, mem_size}, 32'd0);
      chk({tag, "_maddr"}, mem_addr | mem_wr_data, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[32'h10 >> 2] = 32'hDEAD_BEEF;
      mem[32'h40 >> 2] = 32'h0000_0011;
      mem[32'h80 >> 2] = 32'h0000_0022;
      mem_rd_data = 0;
      rst_n = 0;
      idle();

      // Reset: outputs zero even with a request present
      next(); req0(0, 32'h10, 0, 4'hF); settle();
      chk_all_zero("reset");
      next(); idle(); rst_n = 1; settle();
      chk_all_zero("idle_after_reset");

      // Tie after reset: m0, m1, m0
      next(); req0(0, 32'h10, 0, 4'hF); req1(0, 32'h40, 0, 4'hF); settle();
      chk("tie_c0_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
      next(); settle();
      chk("tie_c1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
      chk("tie_c1_rd0", m0_rd_data, 32'hDEAD_BEEF);
      chk("tie_c1_mem_addr", mem_addr, 32'h40);
      next(); settle();
      chk("tie_c2_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
      chk("tie_c2_rsp", {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
      chk("tie_c2_rd1", m1_rd_data, 32'h0000_0011);
      next(); idle(); settle();
      chk("tie_c3_rv0", {31'd0, m0_rvalid}, 32'd1);

      // Single read m0 @0x10
      next(); req0(0, 32'h10, 0, 4'hF); settle();
      chk("single_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
      chk("single_mem", {30'd0, mem_read, mem_write}, 32'd2);
      chk("single_addr", mem_addr, 32'h10);
      next(); idle(); settle();
      chk("single_rv", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
      chk("single_rd0", m0_rd_data, 32'hDEAD_BEEF);
      chk("single_rd1", m1_rd_data, 32'd0);
      chk("single_err", {30'd0, m0_err, m1_err}, 32'd0);
      chk("no_gnt_mem", {30'd0, mem_read, mem_write}, 32'd0);

      // Alternating reads on consecutive cycles
      next(); req0(0, 32'h41, 0, 4'hF); settle();
      chk("alt_gnt0", {31'd0, m0_gnt}, 32'd1);
      chk("alt_addr0", mem_addr, 32'h40);
      next(); idle(); req1(0, 32'h80, 0, 4'hF); settle();
      chk("alt_gnt1", {31'd0, m1_gnt}, 32'd1);
      chk("alt_rv_a", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
      chk("alt_rd0", m0_rd_data, 32'h11);
      next(); idle(); settle();
      chk("alt_rv_b", {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
      chk("alt_rd1", m1_rd_data, 32'h22);
      chk("alt_rd0_zero", m0_rd_data, 32'd0);

      // Out-of-range write then read by m1
      next(); req1(1, 32'h0001_0000, 32'h1234_5678, 4'hF); settle();
      chk("oor_w_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
      chk("oor_w_mem", {30'd0, mem_read, mem_write}, 32'd0);
      next(); req1(0, 32'h0001_0000, 0, 4'hF); settle();
      chk("oor_w_rsp", {28'd0, m0_rvalid, m0_err, m1_rvalid, m1_err}, 32'd1);
      chk("oor_r_gnt", {31'd0, m1_gnt}, 32'd1);
      chk("oor_r_mem", {30'd0, mem_read, mem_write}, 32'd0);
      next(); idle(); settle();
      chk("oor_r_rsp", {28'd0, m0_rvalid, m0_err, m1_rvalid, m1_err}, 32'd3);
      chk("oor_r_rd1", m1_rd_data, 32'd0);
      next(); settle();
      chk("oor_err_pulse", {30'd0, m0_err, m1_err}, 32'd0);

      // Byte write in range
      next(); req0(1, 32'h22, 32'hAABB_CCDD, 4'b0010); settle();
      chk("bw_addr", mem_addr, 32'h20);
      chk("bw_size", {28'd0, mem_size}, 32'h2);
      chk("bw_mem", {30'd0, mem_read, mem_write}, 32'd1);
      chk("bw_data", mem_wr_data, 32'hAABB_CCDD);
      next(); idle(); settle();
      chk("bw_no_rsp", {28'd0, m0_rvalid, m0_err, m1_rvalid, m1_err}, 32'd0);

      // Reset mid-read: m0 was granted last, so a correct reset must restore m0 tie priority
      next(); req0(0, 32'h10, 0, 4'hF); settle();
      chk("rst_rd_gnt", {31'd0, m0_gnt}, 32'd1);
      #1 rst_n = 0; settle();
      chk_all_zero("rst_asserted");
      next(); idle(); settle();
      chk_all_zero("rst_held");
      next(); rst_n = 1; settle();
      chk_all_zero("rst_released");
      next(); req0(0, 32'h40, 0, 4'hF); req1(0, 32'h80, 0, 4'hF); settle();
      chk("rst_tie_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
      next(); idle(); settle();
      chk("rst_tie_rd0", m0_rd_data, 32'h11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_WIDTH, default 14, giving the byte-address width of the data memory.
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 For each requester X in {m0 (core LSU), m1 (DMA/debug)}, the block SHALL provide the following ports.
- i_X_req, input, 1, access request.
- i_X_write, input, 1: 1 = write, 0 = read.
- i_X_addr, input, 32, byte address.
- i_X_wr_data, input, 32, write data.
- i_X_size, input, 4, byte-lane strobes.
REQ-005 For each requester X, the block SHALL provide the following response ports.
- o_X_gnt, output, 1, request accepted this cycle.
- o_X_rvalid, output, 1, read data valid.
- o_X_rd_data, output, 32, read data.
- o_X_err, output, 1, out-of-range response.
REQ-006 The block SHALL provide the following memory-side ports.
- o_mem_addr, output, 32.
- o_mem_wr_data, output, 32.
- o_mem_size, output, 4.
- o_mem_write, output, 1.
- o_mem_read, output, 1.
- i_mem_rd_data, input, 32; read data is valid one cycle after o_mem_read.

Function
REQ-007 Grant SHALL be combinational: o_X_gnt=1 in the same cycle i_X_req=1 if X wins arbitration; at most one gnt per cycle.
REQ-008 When only one requester is active, that requester SHALL win.
REQ-009 When both are active, the requester not granted most recently SHALL win (round-robin); the last-grant pointer SHALL update only on a grant.
REQ-010 The granted request SHALL be driven to memory in the same cycle.
- o_mem_addr = {addr[MEM_ADDR_WIDTH-1:2],2'b00} zero-extended.
- o_mem_wr_data, o_mem_size passed through.
- o_mem_write = write; o_mem_read = ~write.
REQ-011 With no grant, o_mem_read=0 and o_mem_write=0; addr, data and size SHALL hold 0.
REQ-012 A request is in range iff i_X_addr[31:MEM_ADDR_WIDTH]==0; a granted out-of-range request SHALL assert neither o_mem_read nor o_mem_write.
REQ-013 Every granted read SHALL be answered exactly one cycle after grant.
- In range: o_X_rvalid=1 with o_X_rd_data=i_mem_rd_data.
- Out of range: o_X_rvalid=1, o_X_rd_data=0, o_X_err=1.
REQ-014 A granted out-of-range write SHALL pulse o_X_err for one cycle, one cycle after grant; in-range writes produce no response.
REQ-015 Response routing SHALL use a registered tag of the granted requester, so back-to-back grants to alternating requesters each return to the correct owner with no bubble.
REQ-016 o_X_rd_data SHALL be 0 whenever o_X_rvalid=0.
REQ-017 A requester not granted SHALL hold its request stable until granted; the block SHALL not queue requests.

Reset
REQ-018 While i_rst_n=0, all outputs SHALL be 0 and the round-robin pointer SHALL be set to "m1 last", so m0 wins the first tie.
REQ-019 Reset asserted during a cycle in which a read was granted SHALL suppress the pending rvalid/err; no response SHALL appear after reset release.

Verification
REQ-020 Single read: m0 reads 0x10 holding 0xDEADBEEF -> gnt0 same cycle, o_mem_read=1 with addr 0x10, next cycle rvalid0=1 and rd_data0=0xDEADBEEF, rvalid1=0.
REQ-021 Tie after reset: both request in cycle 0 -> gnt0; cycle 1 (both still requesting) -> gnt1; cycle 2 -> gnt0.
REQ-022 Alternating reads: m0 reads addr A (data 0x11), then m1 reads addr B (data 0x22) on consecutive cycles -> rvalid0 with 0x11, then rvalid1 with 0x22, on consecutive cycles.
REQ-023 Out of range: m1 writes 0x0001_0000 (MEM_ADDR_WIDTH=14) -> gnt1, o_mem_write=0, next cycle err1=1; a read to the same address returns rvalid1=1, err1=1, rd_data1=0.
REQ-024 Byte write: m0 writes 0xAABBCCDD with size 4'b0010 to 0x22 -> o_mem_addr=0x20, o_mem_size=4'b0010, o_mem_write=1.
REQ-025 Reset mid-read: grant m0 read, drop i_rst_n in the same cycle -> no rvalid0 in any following cycle, all outputs 0, and the next tie grants m0.
